// File: rtl/grn_pkg.sv
// Shared types for the GRN write path: line/channel types plus a local mirror
// of the CCI-P c1 channel structures and encodings used by the arbiter.
package grn_pkg;

  localparam int unsigned GRN_LINE_BITS      = 512;
  localparam int unsigned GRN_MDATA_CHAN_LSB = 12;

  typedef logic [3:0]               t_grn_chan_id;
  typedef logic [GRN_LINE_BITS-1:0] t_grn_line;
  typedef logic [41:0]              t_ccip_clAddr;

  typedef enum logic [3:0] {
    eREQ_WRLINE_I = 4'h0,
    eREQ_WRLINE_M = 4'h1,
    eREQ_WRPUSH_I = 4'h2,
    eREQ_WRFENCE  = 4'h4,
    eREQ_INTR     = 4'h6
  } t_ccip_c1_req;

  typedef enum logic [3:0] {
    eRSP_WRLINE  = 4'h1,
    eRSP_WRFENCE = 4'h4,
    eRSP_INTR    = 4'h6
  } t_ccip_c1_rsp;

  typedef enum logic [1:0] {
    eVC_VA  = 2'h0,
    eVC_VL0 = 2'h1,
    eVC_VH0 = 2'h2,
    eVC_VH1 = 2'h3
  } t_ccip_vc;

  typedef enum logic [1:0] {
    eCL_LEN_1 = 2'b00,
    eCL_LEN_2 = 2'b01,
    eCL_LEN_4 = 2'b11
  } t_ccip_clLen;

  typedef struct packed {
    logic [5:0]   rsvd2;
    t_ccip_vc     vc_sel;
    logic         sop;
    logic         rsvd1;
    t_ccip_clLen  cl_len;
    t_ccip_c1_req req_type;
    logic [5:0]   rsvd0;
    t_ccip_clAddr address;
    logic [15:0]  mdata;
  } t_ccip_c1_ReqMemHdr;

  typedef struct packed {
    t_ccip_c1_ReqMemHdr hdr;
    t_grn_line          data;
    logic               valid;
  } t_if_ccip_c1_Tx;

  typedef struct packed {
    t_ccip_vc     vc_used;
    logic         rsvd1;
    logic         hit_miss;
    logic         format;
    logic         rsvd0;
    logic [1:0]   cl_num;
    t_ccip_c1_rsp resp_type;
    logic [15:0]  mdata;
  } t_ccip_c1_RspMemHdr;

  typedef struct packed {
    t_ccip_c1_RspMemHdr hdr;
    logic               rspValid;
  } t_if_ccip_c1_Rx;

endpackage

// File: rtl/grn_chan_fifo.sv
// Single-clock show-ahead FIFO holding result lines for one core channel.
module grn_chan_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 512
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_rdata   = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + (AW+1)'(1);
      if (w_do_pop)  r_rptr <= r_rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/grn_write_arbiter.sv
// Merges result lines from NUM_CHANNELS cores onto the CCI-P c1 write stream,
// round-robin, into per-channel ring buffers, and tracks write completion.
module grn_write_arbiter
  import grn_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS    = 4,
  parameter int unsigned FIFO_DEPTH      = 8,
  parameter int unsigned RING_LINES_LOG2 = 10,
  parameter int unsigned OUTST_WIDTH     = 9
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic [NUM_CHANNELS*42-1:0]  base_addr,
  input  logic [NUM_CHANNELS-1:0]     req_write,
  input  logic [NUM_CHANNELS*512-1:0] transient,
  input  logic [NUM_CHANNELS-1:0]     finish,
  output logic [NUM_CHANNELS-1:0]     ack_write,
  input  logic                        c1TxAlmFull,
  input  t_if_ccip_c1_Rx              c1Rx,
  output t_if_ccip_c1_Tx              c1Tx,
  output logic [NUM_CHANNELS*32-1:0]  lines_written,
  output logic [NUM_CHANNELS-1:0]     chan_done,
  output logic                        all_done
);

  logic [NUM_CHANNELS-1:0]    r_ack;
  logic [NUM_CHANNELS-1:0]    w_push;
  logic [NUM_CHANNELS-1:0]    w_full;
  logic [NUM_CHANNELS-1:0]    w_empty;
  logic [NUM_CHANNELS-1:0]    w_elig;
  logic [NUM_CHANNELS-1:0]    w_hi;
  logic [NUM_CHANNELS-1:0]    w_cand;
  logic [NUM_CHANNELS-1:0]    w_grant;
  logic [NUM_CHANNELS-1:0]    w_rsp_hit;
  logic [NUM_CHANNELS-1:0]    w_done_cond;
  logic [NUM_CHANNELS-1:0]    r_done;
  logic                       r_all_done;
  t_grn_line                  w_rdata [NUM_CHANNELS];
  logic [RING_LINES_LOG2-1:0] r_ring_off [NUM_CHANNELS];
  logic [OUTST_WIDTH-1:0]     r_outst [NUM_CHANNELS];
  logic [31:0]                r_lines [NUM_CHANNELS];
  t_grn_chan_id               r_rr;
  t_grn_chan_id               w_win;
  logic                       w_any;
  logic                       w_go;
  t_grn_line                  w_sel_data;
  t_ccip_clAddr               w_sel_addr;
  logic [41:0]                w_sel_off;
  t_ccip_c1_ReqMemHdr         w_hdr;
  t_if_ccip_c1_Tx             r_c1Tx;
  logic                       w_rsp_ok;
  t_grn_chan_id               w_rsp_chan;
  logic                       w_unused_rsp;

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_chan
    grn_chan_fifo #(
      .DEPTH(FIFO_DEPTH),
      .WIDTH(GRN_LINE_BITS)
    ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push[g]),
      .i_wdata (transient[g*512 +: 512]),
      .i_pop   (w_grant[g]),
      .o_rdata (w_rdata[g]),
      .o_full  (w_full[g]),
      .o_empty (w_empty[g])
    );
  end

  // Ack is withheld while it is already high so a held req is pushed only once.
  assign w_push = req_write & ~w_full & ~r_ack;

  always_ff @(posedge clk) begin
    if (!rst_n) r_ack <= '0;
    else        r_ack <= w_push;
  end

  // Round-robin: lowest eligible channel at/above r_rr, else lowest overall.
  always_comb begin
    w_elig = '0;
    w_hi   = '0;
    for (int unsigned k = 0; k < NUM_CHANNELS; k++) begin
      w_elig[k] = !w_empty[k] && (r_outst[k] != '1);
      w_hi[k]   = w_elig[k] && (k >= 32'(r_rr));
    end
    w_cand = (|w_hi) ? w_hi : w_elig;
    w_any  = 1'b0;
    w_win  = '0;
    for (int unsigned k = NUM_CHANNELS; k > 0; k--) begin
      if (w_cand[k-1]) begin
        w_any = 1'b1;
        w_win = t_grn_chan_id'(k-1);
      end
    end
    w_go    = enable && !c1TxAlmFull && w_any;
    w_grant = '0;
    for (int unsigned k = 0; k < NUM_CHANNELS; k++) begin
      w_grant[k] = w_go && (w_win == t_grn_chan_id'(k));
    end
  end

  always_comb begin
    w_sel_data = '0;
    w_sel_off  = '0;
    w_sel_addr = '0;
    for (int unsigned k = 0; k < NUM_CHANNELS; k++) begin
      if (w_grant[k]) begin
        w_sel_data = w_rdata[k];
        w_sel_off  = 42'(r_ring_off[k]);
        w_sel_addr = base_addr[k*42 +: 42] + 42'(r_ring_off[k]);
      end
    end
    w_hdr          = '0;
    w_hdr.vc_sel   = eVC_VA;
    w_hdr.sop      = 1'b1;
    w_hdr.cl_len   = eCL_LEN_1;
    w_hdr.req_type = eREQ_WRLINE_I;
    w_hdr.address  = w_sel_addr;
    w_hdr.mdata[GRN_MDATA_CHAN_LSB +: 4]    = w_win;
    w_hdr.mdata[GRN_MDATA_CHAN_LSB-1:0]     = w_sel_off[GRN_MDATA_CHAN_LSB-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_c1Tx <= '0;
      r_rr   <= '0;
    end else begin
      r_c1Tx.valid <= w_go;
      if (w_go) begin
        r_c1Tx.hdr  <= w_hdr;
        r_c1Tx.data <= w_sel_data;
        r_rr        <= (w_win == t_grn_chan_id'(NUM_CHANNELS-1)) ? '0 : w_win + 4'd1;
      end
    end
  end

  assign c1Tx = r_c1Tx;

  assign w_rsp_ok     = c1Rx.rspValid && (c1Rx.hdr.resp_type == eRSP_WRLINE);
  assign w_rsp_chan   = c1Rx.hdr.mdata[GRN_MDATA_CHAN_LSB +: 4];
  assign w_unused_rsp = ^c1Rx.hdr;

  // A response only counts against a non-zero outstanding count, so responses
  // to writes issued before a reset are dropped.
  always_comb begin
    w_rsp_hit   = '0;
    w_done_cond = '0;
    for (int unsigned k = 0; k < NUM_CHANNELS; k++) begin
      w_rsp_hit[k]   = w_rsp_ok && (w_rsp_chan == t_grn_chan_id'(k)) && (r_outst[k] != '0);
      w_done_cond[k] = finish[k] && !req_write[k] && w_empty[k] && !w_grant[k]
                       && (r_outst[k] == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < NUM_CHANNELS; k++) begin
        r_ring_off[k] <= '0;
        r_outst[k]    <= '0;
        r_lines[k]    <= '0;
      end
      r_done     <= '0;
      r_all_done <= 1'b0;
    end else begin
      for (int unsigned k = 0; k < NUM_CHANNELS; k++) begin
        if (w_grant[k]) r_ring_off[k] <= r_ring_off[k] + RING_LINES_LOG2'(1);
        case ({w_grant[k], w_rsp_hit[k]})
          2'b10:   r_outst[k] <= r_outst[k] + OUTST_WIDTH'(1);
          2'b01:   r_outst[k] <= r_outst[k] - OUTST_WIDTH'(1);
          default: r_outst[k] <= r_outst[k];
        endcase
        if (w_rsp_hit[k])   r_lines[k] <= r_lines[k] + 32'd1;
        if (w_done_cond[k]) r_done[k]  <= 1'b1;
      end
      r_all_done <= &r_done;
    end
  end

  always_comb begin
    lines_written = '0;
    for (int unsigned k = 0; k < NUM_CHANNELS; k++) begin
      lines_written[k*32 +: 32] = r_lines[k];
    end
  end

  assign ack_write = r_ack;
  assign chan_done = r_done;
  assign all_done  = r_all_done;

endmodule

// File: tb/tb_grn_write_arbiter.sv
// Directed bench for grn_write_arbiter: four channels, 4-line rings so that
// address wrap is visible, cores modelled as req/ack line producers.
module tb_grn_write_arbiter;
  import grn_pkg::*;

  localparam int NCH = 4;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 enable;
  logic [NCH*42-1:0]    base_addr = {42'h2000, 42'h1000, 42'h40, 42'h0};
  logic [NCH-1:0]       req_write = '0;
  logic [NCH*512-1:0]   transient = '0;
  logic [NCH-1:0]       finish;
  logic [NCH-1:0]       ack_write;
  logic                 c1TxAlmFull;
  t_if_ccip_c1_Rx       c1Rx;
  t_if_ccip_c1_Tx       c1Tx;
  logic [NCH*32-1:0]    lines_written;
  logic [NCH-1:0]       chan_done;
  logic                 all_done;

  int n_checks = 0;
  int n_errors = 0;

  int want [NCH];
  int sent [NCH];

  int n_issue;
  int n_iss [NCH];
  int n_ack [NCH];
  int n_bad_addr, n_bad_hdr, n_bad_data, n_almfull_viol;
  logic [41:0] q_addr [$];
  int          q_chan [$];

  always #5 clk = ~clk;

  grn_write_arbiter #(
    .NUM_CHANNELS(NCH),
    .FIFO_DEPTH(8),
    .RING_LINES_LOG2(2),
    .OUTST_WIDTH(9)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .base_addr     (base_addr),
    .req_write     (req_write),
    .transient     (transient),
    .finish        (finish),
    .ack_write     (ack_write),
    .c1TxAlmFull   (c1TxAlmFull),
    .c1Rx          (c1Rx),
    .c1Tx          (c1Tx),
    .lines_written (lines_written),
    .chan_done     (chan_done),
    .all_done      (all_done)
  );

  function automatic logic [511:0] line_of(input int ch, input int s);
    logic [511:0] l;
    l          = '0;
    l[15:0]    = 16'(s);
    l[19:16]   = 4'(ch);
    l[511:480] = 32'h5EED_0000 + 32'(s);
    return l;
  endfunction

  // Core model: raise req with the next line, drop it on ack.
  always @(posedge clk) begin
    #2;
    for (int c = 0; c < NCH; c++) begin
      if (!rst_n) begin
        req_write[c] = 1'b0;
        sent[c]      = 0;
      end else if (ack_write[c]) begin
        req_write[c] = 1'b0;
        sent[c]      = sent[c] + 1;
      end else if (!req_write[c] && sent[c] < want[c]) begin
        req_write[c]           = 1'b1;
        transient[c*512 +: 512] = line_of(c, sent[c]);
      end
    end
  end

  // Issue monitor with a per-channel ring model.
  always @(posedge clk) begin
    int          ch;
    logic [41:0] exp_addr;
    #1;
    if (!rst_n) begin
      n_issue = 0; n_bad_addr = 0; n_bad_hdr = 0; n_bad_data = 0; n_almfull_viol = 0;
      for (int c = 0; c < NCH; c++) begin n_iss[c] = 0; n_ack[c] = 0; end
      q_addr.delete();
      q_chan.delete();
    end else begin
      for (int c = 0; c < NCH; c++) if (ack_write[c]) n_ack[c]++;
      if (c1Tx.valid) begin
        ch = int'(c1Tx.hdr.mdata[15:12]);
        if (c1TxAlmFull) n_almfull_viol++;
        if (c1Tx.hdr.req_type !== eREQ_WRLINE_I || c1Tx.hdr.sop !== 1'b1 ||
            c1Tx.hdr.cl_len !== eCL_LEN_1 || c1Tx.hdr.vc_sel !== eVC_VA) n_bad_hdr++;
        if (ch >= NCH) n_bad_hdr++;
        else begin
          exp_addr = base_addr[ch*42 +: 42] + 42'(n_iss[ch] % 4);
          if (c1Tx.hdr.address !== exp_addr) n_bad_addr++;
          if (c1Tx.hdr.mdata[11:0] !== 12'(n_iss[ch] % 4)) n_bad_hdr++;
          if (c1Tx.data !== line_of(ch, n_iss[ch])) n_bad_data++;
          n_iss[ch]++;
        end
        q_addr.push_back(c1Tx.hdr.address);
        q_chan.push_back(ch);
        n_issue++;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n       = 1'b0;
    finish      = '0;
    c1TxAlmFull = 1'b0;
    c1Rx        = '0;
    for (int c = 0; c < NCH; c++) want[c] = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic rsp(input int ch);
    c1Rx                = '0;
    c1Rx.rspValid       = 1'b1;
    c1Rx.hdr.resp_type  = eRSP_WRLINE;
    c1Rx.hdr.mdata      = 16'(ch) << 12;
    @(negedge clk);
    c1Rx = '0;
  endtask

  task automatic wait_issues(input int n, input int budget, input string tag);
    int t = 0;
    while (n_issue < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk(tag, 64'(n_issue >= n), 64'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [41:0] ring_exp [6];
    int          ord_err;
    ring_exp = '{42'h40, 42'h41, 42'h42, 42'h43, 42'h40, 42'h41};

    rst_n = 1'b0; enable = 1'b1; c1TxAlmFull = 1'b0; finish = '0; c1Rx = '0;
    for (int c = 0; c < NCH; c++) want[c] = 0;
    do_reset();
    chk("rst_ack", 64'(ack_write), 64'd0);
    chk("rst_valid", 64'(c1Tx.valid), 64'd0);
    chk("rst_lines", 64'(lines_written == '0), 64'd1);
    chk("rst_done", 64'(chan_done), 64'd0);
    chk("rst_all_done", 64'(all_done), 64'd0);

    // Single line on ch2
    want[2] = 1;
    @(negedge clk); chk("t1_ack_early", 64'(ack_write), 64'd0);
    @(negedge clk); chk("t1_ack", 64'(ack_write), 64'b0100);
    @(negedge clk);
    chk("t1_valid", 64'(c1Tx.valid), 64'd1);
    chk("t1_addr", 64'(c1Tx.hdr.address), 64'h1000);
    chk("t1_mdata", 64'(c1Tx.hdr.mdata), 64'h2000);
    chk("t1_type", 64'(c1Tx.hdr.req_type), 64'(eREQ_WRLINE_I));
    chk("t1_data", 64'(c1Tx.data == line_of(2, 0)), 64'd1);
    rsp(6);
    chk("t1_pulse", 64'(c1Tx.valid), 64'd0);
    chk("t1_unmapped", 64'(lines_written == '0), 64'd1);
    rsp(2);
    chk("t1_lw2", 64'(lines_written[95:64]), 64'd1);
    chk("t1_lw_other", 64'({lines_written[127:96], lines_written[63:0]}), 64'd0);

    // Fairness: all channels stream 100 lines
    do_reset();
    for (int c = 0; c < NCH; c++) want[c] = 100;
    wait_issues(400, 2000, "t2_timeout");
    ord_err = 0;
    for (int k = 0; k < q_chan.size(); k++) if (q_chan[k] != k % 4) ord_err++;
    chk("t2_rr_order", 64'(ord_err), 64'd0);
    for (int c = 0; c < NCH; c++) chk("t2_share", 64'(n_iss[c]), 64'd100);
    chk("t2_addr", 64'(n_bad_addr), 64'd0);
    chk("t2_data", 64'(n_bad_data), 64'd0);
    chk("t2_hdr", 64'(n_bad_hdr), 64'd0);
    repeat (10) @(negedge clk);
    chk("t2_no_extra", 64'(n_issue), 64'd400);

    // almFull back-pressure with ch0 streaming
    do_reset();
    c1TxAlmFull = 1'b1;
    want[0] = 20;
    repeat (20) @(negedge clk);
    chk("t3_acks_full", 64'(n_ack[0]), 64'd8);
    chk("t3_no_issue", 64'(n_issue), 64'd0);
    chk("t3_ack_held", 64'(ack_write), 64'd0);
    c1TxAlmFull = 1'b0;
    wait_issues(20, 300, "t3_timeout");
    chk("t3_drained", 64'(n_iss[0]), 64'd20);
    chk("t3_acks_all", 64'(n_ack[0]), 64'd20);
    chk("t3_almfull_viol", 64'(n_almfull_viol), 64'd0);
    chk("t3_addr", 64'(n_bad_addr), 64'd0);

    // Ring wrap on ch1 with a 4-line ring
    do_reset();
    want[1] = 6;
    wait_issues(6, 100, "t4_timeout");
    for (int k = 0; k < 6; k++) chk("t4_ring_addr", 64'(q_addr[k]), 64'(ring_exp[k]));
    chk("t4_mdata", 64'(n_bad_hdr), 64'd0);

    // Completion tracking
    do_reset();
    want[0] = 3;
    wait_issues(3, 100, "t5_timeout");
    repeat (2) @(negedge clk);
    finish[0] = 1'b1;
    @(negedge clk); chk("t5_done_outst", 64'(chan_done), 64'd0);
    rsp(0);
    rsp(0);
    chk("t5_done_2rsp", 64'(chan_done), 64'd0);
    rsp(0);
    chk("t5_done_same", 64'(chan_done), 64'd0);
    chk("t5_lw0", 64'(lines_written[31:0]), 64'd3);
    @(negedge clk);
    chk("t5_done0", 64'(chan_done), 64'b0001);
    chk("t5_all_early", 64'(all_done), 64'd0);
    finish = '1;
    @(negedge clk);
    chk("t5_done_all", 64'(chan_done), 64'hF);
    chk("t5_all_lag", 64'(all_done), 64'd0);
    @(negedge clk);
    chk("t5_all_done", 64'(all_done), 64'd1);

    // Reset mid-traffic, then a late response
    do_reset();
    want[3] = 4;
    wait_issues(2, 100, "t6_timeout");
    rsp(3);
    chk("t6_lw3_pre", 64'(lines_written[127:96]), 64'd1);
    rst_n   = 1'b0;
    want[3] = 0;
    @(negedge clk);
    chk("t6_ack", 64'(ack_write), 64'd0);
    chk("t6_valid", 64'(c1Tx.valid), 64'd0);
    chk("t6_lines", 64'(lines_written == '0), 64'd1);
    chk("t6_done", 64'({chan_done, all_done}), 64'd0);
    rst_n = 1'b1;
    rsp(3);
    chk("t6_late_rsp", 64'(lines_written == '0), 64'd1);
    repeat (5) @(negedge clk);
    chk("t6_discard", 64'(n_issue), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
